// File: rtl/sysbus_arb_pkg.sv
// Shared state/owner types and constants for the Sysbus I/D arbiter.
// Optional fixed D priority is selected with SYSBUS_ARB_DPRIO_EN.
package sysbus_arb_pkg;

    localparam int TAG_READ_BIT = 12;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE,
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-input grant logic for the Sysbus arbiter; owns the last_grant state.
// SYSBUS_ARB_DPRIO_EN selects fixed D priority instead of round-robin.
import sysbus_arb_pkg::*;

module arb_rr2 (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_i,
    input  logic req_d,
    output logic gnt_i,
    output logic gnt_d
);

`ifdef SYSBUS_ARB_DPRIO_EN
    logic unused_ok;
    assign unused_ok = clk ^ reset;

    always_comb begin
        gnt_d = en & req_d;
        gnt_i = en & req_i & ~req_d;
    end
`else
    owner_t last_grant;

    // On a tie the side that did not win last time takes the bus
    always_comb begin
        gnt_i = en & req_i & (~req_d | (last_grant == OWN_D));
        gnt_d = en & req_d & (~req_i | (last_grant == OWN_I));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= OWN_D;
        end else if (gnt_i) begin
            last_grant <= OWN_I;
        end else if (gnt_d) begin
            last_grant <= OWN_D;
        end
    end
`endif

endmodule

// File: rtl/sysbus_arbiter.sv
// Shares one Sysbus memory port between the I-cache and D-cache requesters.
// Define SYSBUS_ARB_DPRIO_EN for fixed D priority (default round-robin).
import sysbus_arb_pkg::*;

module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = TAG_READ_BIT + 1,
    parameter int RESP_BEATS     = 8,
    parameter int WR_BEATS       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] i_req,
    input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
    output logic                      i_reqack,
    output logic                      i_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] i_resp,
    output logic [BUS_TAG_WIDTH-1:0]  i_resptag,
    input  logic                      i_respack,
    input  logic                      d_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] d_req,
    input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
    output logic                      d_reqack,
    output logic                      d_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] d_resp,
    output logic [BUS_TAG_WIDTH-1:0]  d_resptag,
    input  logic                      d_respack,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    localparam int RQ_W = $clog2(WR_BEATS + 2);
    localparam int RS_W = $clog2(RESP_BEATS + 1);

    arb_state_t      state;
    owner_t          owner;
    logic            is_write;
    logic [RQ_W-1:0] req_cnt;
    logic [RS_W-1:0] resp_cnt;

    logic gnt_i;
    logic gnt_d;
    logic own_i;
    logic req_fire;
    logic resp_fire;

    arb_rr2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (state == IDLE),
        .req_i (i_reqcyc),
        .req_d (d_reqcyc),
        .gnt_i (gnt_i),
        .gnt_d (gnt_d)
    );

    assign own_i     = (owner == OWN_I);
    assign req_fire  = bus_reqcyc & bus_reqack;
    assign resp_fire = bus_respcyc & bus_respack;

    // Request/response routing; everything is quiet outside the owning phase
    always_comb begin
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        i_reqack    = 1'b0;
        d_reqack    = 1'b0;
        i_respcyc   = 1'b0;
        i_resp      = '0;
        i_resptag   = '0;
        d_respcyc   = 1'b0;
        d_resp      = '0;
        d_resptag   = '0;
        bus_respack = 1'b0;
        unique case (state)
            REQ: begin
                bus_reqcyc = own_i ? i_reqcyc : d_reqcyc;
                bus_req    = own_i ? i_req    : d_req;
                bus_reqtag = own_i ? i_reqtag : d_reqtag;
                i_reqack   = own_i & bus_reqack;
                d_reqack   = ~own_i & bus_reqack;
            end
            RESP: begin
                if (own_i) begin
                    i_respcyc   = bus_respcyc;
                    i_resp      = bus_resp;
                    i_resptag   = bus_resptag;
                    bus_respack = i_respack;
                end else begin
                    d_respcyc   = bus_respcyc;
                    d_resp      = bus_resp;
                    d_resptag   = bus_resptag;
                    bus_respack = d_respack;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= NONE;
            is_write <= 1'b0;
            req_cnt  <= '0;
            resp_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_i | gnt_d) begin
                        owner    <= gnt_i ? OWN_I : OWN_D;
                        is_write <= gnt_i ? ~i_reqtag[BUS_TAG_WIDTH-1]
                                          : ~d_reqtag[BUS_TAG_WIDTH-1];
                        req_cnt  <= '0;
                        resp_cnt <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    // Owner withdrawing mid-request abandons the transaction
                    if (!bus_reqcyc) begin
                        state <= IDLE;
                        owner <= NONE;
                    end else if (req_fire) begin
                        req_cnt <= req_cnt + 1'b1;
                        if (!is_write) begin
                            state <= RESP;
                        end else if (req_cnt == RQ_W'(WR_BEATS)) begin
                            state <= IDLE;
                            owner <= NONE;
                        end
                    end
                end
                RESP: begin
                    if (resp_fire) begin
                        resp_cnt <= resp_cnt + 1'b1;
                        if (resp_cnt == RS_W'(RESP_BEATS - 1)) begin
                            state <= IDLE;
                            owner <= NONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
